// File: rtl/rv32i_issue_scoreboard.sv
// rv32i_issue_scoreboard: register scoreboard with a one-entry issue staging register for RV32I.
// Ports:
//   clk, rst                sole clock; synchronous active-high reset
//   dec_valid/dec_ready     decoded instruction handshake, dec_inst is the raw word
//   issue_valid/issue_ready staged instruction handshake, issue_inst is the staged word
//   wb_valid, wb_rd         writeback completion and its destination register
//   flush                   discard the staged instruction and all tracking
//   busy                    pending-write bit per register (bit 0 always 0)
//   inflight                issued-but-not-written-back count
// Build option: RV32I_SCOREBOARD_WB_BYPASS_EN lets a writeback clear its register
//   from the hazard check in the same cycle.
module rv32i_issue_scoreboard #(
   parameter int MAX_INFLIGHT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        dec_valid,
   output logic        dec_ready,
   input  logic [31:0] dec_inst,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [31:0] issue_inst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        flush,
   output logic [31:0] busy,
   output logic [3:0]  inflight
);
   typedef enum logic {EMPTY, FULL} state_t;
   state_t state, state_n;
   logic [6:0] opc;
   logic [2:0] f3;
   logic [4:0] rd, rs1, rs2;
   logic is_op, is_imm, is_load, is_store, is_jalr, is_branch, is_sys, is_lui, is_auipc, is_jal;
   logic rd_rs1, rd_rs2, wr_rd, hazard, acc, wb_eff;
   logic [31:0] hz_busy, busy_n;
   logic [3:0] inflight_n;
   assign opc = dec_inst[6:0];
   assign f3 = dec_inst[14:12];
   assign rd = dec_inst[11:7];
   assign rs1 = dec_inst[19:15];
   assign rs2 = dec_inst[24:20];
   assign is_op = opc == 7'b0110011;
   assign is_imm = opc == 7'b0010011;
   assign is_load = opc == 7'b0000011;
   assign is_store = opc == 7'b0100011;
   assign is_jalr = opc == 7'b1100111;
   assign is_branch = opc == 7'b1100011;
   assign is_sys = opc == 7'b1110011;
   assign is_lui = opc == 7'b0110111;
   assign is_auipc = opc == 7'b0010111;
   assign is_jal = opc == 7'b1101111;
   // CSR ops with funct3 1..3 read rs1; the immediate forms (5..7) do not
   assign rd_rs1 = is_op | is_imm | is_load | is_store | is_jalr | is_branch
                 | (is_sys & (f3 == 3'd1 | f3 == 3'd2 | f3 == 3'd3));
   assign rd_rs2 = is_op | is_store | is_branch;
   assign wr_rd = (is_op | is_imm | is_load | is_lui | is_auipc | is_jal | is_jalr
                 | (is_sys & f3 != 3'd0)) & rd != 5'd0;
   // a writeback with nothing outstanding is spurious and dropped
   assign wb_eff = wb_valid & inflight != 4'd0 & !flush & !rst;
   always_comb begin
      hz_busy = busy;
`ifdef RV32I_SCOREBOARD_WB_BYPASS_EN
      if (wb_eff) hz_busy[wb_rd] = 1'b0;
`else
`endif
   end
   assign hazard = (rd_rs1 & hz_busy[rs1]) | (rd_rs2 & hz_busy[rs2]) | (wr_rd & hz_busy[rd]);
   assign issue_valid = state == FULL;
   assign dec_ready = dec_valid & !hazard & !flush & !rst & (inflight < 4'(MAX_INFLIGHT))
                    & (!issue_valid | issue_ready);
   assign acc = dec_ready;
   always_comb begin
      state_n = state;
      if (rst | flush) state_n = EMPTY;
      else if (acc) state_n = FULL;
      else if (issue_ready) state_n = EMPTY;
   end
   // set after clear so an accepted rd matching wb_rd stays busy
   always_comb begin
      busy_n = busy;
      if (wb_eff) busy_n[wb_rd] = 1'b0;
      if (acc & wr_rd) busy_n[rd] = 1'b1;
      busy_n[0] = 1'b0;
   end
   assign inflight_n = (acc & !wb_eff) ? inflight + 4'd1 : (wb_eff & !acc) ? inflight - 4'd1 : inflight;
   always_ff @(posedge clk) begin
      if (rst | flush) begin
         state <= EMPTY;
         issue_inst <= '0;
         busy <= '0;
         inflight <= '0;
      end else begin
         state <= state_n;
         busy <= busy_n;
         inflight <= inflight_n;
         if (acc) issue_inst <= dec_inst;
      end
   end
endmodule

// File: tb/tb_rv32i_issue_scoreboard.sv
// tb_rv32i_issue_scoreboard: directed-vector bench for rv32i_issue_scoreboard.
module tb_rv32i_issue_scoreboard;
   logic clk = 0, rst = 1, dec_valid = 0, issue_ready = 0, wb_valid = 0, flush = 0;
   logic dec_ready, issue_valid;
   logic [31:0] dec_inst = 0, issue_inst, busy;
   logic [4:0] wb_rd = 0;
   logic [3:0] inflight;
   int n = 0, errs = 0;
   rv32i_issue_scoreboard #(.MAX_INFLIGHT(4)) dut (
      .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_inst(issue_inst),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .busy(busy), .inflight(inflight)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic state(input string tag, input logic iv, input logic [31:0] b, input logic [3:0] inf);
      chk({tag, ".issue_valid"}, 32'(issue_valid), 32'(iv));
      chk({tag, ".busy"}, busy, b);
      chk({tag, ".inflight"}, 32'(inflight), 32'(inf));
   endtask
   task automatic do_flush();
      flush = 1;
      cyc();
      flush = 0;
   endtask
   function automatic logic [31:0] addi(input int r);
      return 32'h00500013 | (32'(r) << 7);
   endfunction
   initial begin
      dec_valid = 1;
      dec_inst = addi(1);
      #1;
      chk("rst_ready", 32'(dec_ready), 0);
      cyc();
      cyc();
      state("reset", 0, 0, 0);
      chk("reset.issue_inst", issue_inst, 0);
      rst = 0;
      issue_ready = 1;
      dec_inst = 32'h00500093;
      #1;
      chk("addi.ready", 32'(dec_ready), 1);
      cyc();
      state("addi", 1, 32'h2, 1);
      chk("addi.inst", issue_inst, 32'h00500093);
      dec_inst = 32'h002081B3;
      #1;
      chk("raw.stall", 32'(dec_ready), 0);
      cyc();
      chk("raw.drain", 32'(issue_valid), 0);
      wb_valid = 1;
      wb_rd = 1;
      #1;
`ifdef RV32I_SCOREBOARD_WB_BYPASS_EN
      chk("raw.bypass_ready", 32'(dec_ready), 1);
      cyc();
      wb_valid = 0;
      dec_valid = 0;
      state("raw.bypass", 1, 32'h8, 1);
`else
      chk("raw.wb_ready", 32'(dec_ready), 0);
      cyc();
      wb_valid = 0;
      state("raw.wb", 0, 0, 0);
      #1;
      chk("raw.after_ready", 32'(dec_ready), 1);
      cyc();
      dec_valid = 0;
      state("raw.accept", 1, 32'h8, 1);
`endif
      chk("raw.inst", issue_inst, 32'h002081B3);
      do_flush();
      state("flush1", 0, 0, 0);
      dec_valid = 1;
      for (int i = 1; i <= 4; i++) begin
         dec_inst = addi(i);
         #1;
         chk($sformatf("max.ready%0d", i), 32'(dec_ready), 1);
         cyc();
      end
      state("max4", 1, 32'h1E, 4);
      dec_inst = addi(5);
      #1;
      chk("max.stall", 32'(dec_ready), 0);
      cyc();
      chk("max.stall2", 32'(dec_ready), 0);
      wb_valid = 1;
      wb_rd = 1;
      cyc();
      wb_valid = 0;
      state("max.wb", 0, 32'h1C, 3);
      #1;
      chk("max.fifth_ready", 32'(dec_ready), 1);
      cyc();
      dec_valid = 0;
      state("max.fifth", 1, 32'h3C, 4);
      chk("max.inst", issue_inst, addi(5));
      do_flush();
      issue_ready = 0;
      dec_valid = 1;
      dec_inst = addi(1);
      cyc();
      dec_inst = addi(2);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("hold.ready%0d", i), 32'(dec_ready), 0);
         cyc();
         chk($sformatf("hold.inst%0d", i), issue_inst, addi(1));
         chk($sformatf("hold.valid%0d", i), 32'(issue_valid), 1);
      end
      issue_ready = 1;
      #1;
      chk("b2b.ready", 32'(dec_ready), 1);
      cyc();
      dec_valid = 0;
      state("b2b", 1, 32'h6, 2);
      chk("b2b.inst", issue_inst, addi(2));
      cyc();
      chk("b2b.drain", 32'(issue_valid), 0);
      do_flush();
      dec_valid = 1;
      dec_inst = addi(1);
      cyc();
      dec_inst = 32'h00102023;
      #1;
      chk("store.rs2_stall", 32'(dec_ready), 0);
      dec_inst = 32'h0000000F;
      #1;
      chk("fence.ready", 32'(dec_ready), 1);
      cyc();
      state("fence", 1, 32'h2, 2);
      dec_inst = addi(7);
      wb_valid = 1;
      wb_rd = 7;
      #1;
      chk("x7.ready", 32'(dec_ready), 1);
      cyc();
      wb_valid = 0;
      dec_valid = 0;
      state("x7", 1, 32'h82, 2);
      do_flush();
      wb_valid = 1;
      wb_rd = 3;
      cyc();
      wb_valid = 0;
      state("underflow", 0, 0, 0);
      dec_valid = 1;
      for (int i = 1; i <= 3; i++) begin
         dec_inst = addi(i);
         cyc();
      end
      state("preflush", 1, 32'hE, 3);
      dec_inst = addi(4);
      wb_valid = 1;
      wb_rd = 1;
      flush = 1;
      #1;
      chk("flush.ready", 32'(dec_ready), 0);
      cyc();
      flush = 0;
      wb_valid = 0;
      state("flush", 0, 0, 0);
      cyc();
      rst = 1;
      #1;
      chk("midrst.ready", 32'(dec_ready), 0);
      cyc();
      rst = 0;
      dec_valid = 0;
      state("midrst", 0, 0, 0);
      chk("midrst.inst", issue_inst, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n, errs);
      $finish;
   end
endmodule

// File: doc/rv32i_issue_scoreboard.md
RV32I_ISSUE_SCOREBOARD -- requirements
Module: rv32i_issue_scoreboard

Interface
REQ-001 SHALL have parameter: MAX_INFLIGHT, 4, maximum issued-but-not-written-back instructions (2..15).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: dec_valid  input  1  decoded instruction offered.
REQ-005 SHALL have port: dec_ready  output  1  instruction accepted this cycle.
REQ-006 SHALL have port: dec_inst  input  32  raw RV32I instruction word.
REQ-007 SHALL have port: issue_valid  output  1  staged instruction present.
REQ-008 SHALL have port: issue_ready  input  1  execute stage consumes staged instruction.
REQ-009 SHALL have port: issue_inst  output  32  staged instruction word.
REQ-010 SHALL have port: wb_valid  input  1  writeback completes.
REQ-011 SHALL have port: wb_rd  input  5  writeback destination register.
REQ-012 SHALL have port: flush  input  1  discard staged instruction and all tracking.
REQ-013 SHALL have port: busy  output  32  pending-write bit per register; bit 0 always 0.
REQ-014 SHALL have port: inflight  output  4  count of outstanding instructions.

Function
REQ-015 SHALL classify dec_inst by opcode[6:0]: reads rs1 for OP, IMM, LOAD, STORE, JALR, BRANCH, SYSTEM with funct3 in {1,2,3}.
REQ-016 SHALL classify reads rs2 for OP, STORE, BRANCH only.
REQ-017 SHALL classify writes rd for OP, IMM, LOAD, LUI, AUIPC, JAL, JALR, SYSTEM with funct3 != 0; writes to x0 are never tracked.
REQ-018 SHALL treat FENCE, ECALL/EBREAK and unknown opcodes as no-read/no-write; they issue without hazard check but still count in inflight.
REQ-019 SHALL raise hazard when any read source or tracked rd (WAW) has its busy bit set.
REQ-020 SHALL drive dec_ready = dec_valid & !hazard & !flush & (inflight < MAX_INFLIGHT) & (!issue_valid | issue_ready), combinationally.
REQ-021 SHALL hold a one-entry staging register with states EMPTY/FULL: EMPTY->FULL on accept; FULL->EMPTY on issue_ready without accept; FULL->FULL on simultaneous consume and accept (new word replaces old, zero bubble).
REQ-022 SHALL hold issue_inst stable while issue_valid & !issue_ready.
REQ-023 SHALL set busy[rd] and increment inflight on accept; latency dec accept -> issue_valid is 1 cycle.
REQ-024 SHALL clear busy[wb_rd] and decrement inflight on wb_valid; wb_rd = 0 only decrements.
REQ-025 SHALL, on simultaneous accept and wb_valid, leave inflight unchanged; if accepted rd equals wb_rd, set wins.
REQ-026 SHALL ignore wb_valid when inflight = 0 (no underflow).
REQ-027 SHALL, on flush, clear staging register, busy and inflight next cycle; dec_ready and wb_valid are ignored that cycle.

Reset
REQ-028 SHALL, while rst is high at a clock edge, set state EMPTY, issue_valid 0, issue_inst 0, busy 0, inflight 0.
REQ-029 SHALL hold dec_ready 0 during any cycle rst is high; rst mid-operation discards staged and tracked state identically to flush.

Configuration
REQ-030 SHALL, with RV32I_SCOREBOARD_WB_BYPASS_EN defined, mask busy[wb_rd] out of the hazard check when wb_valid, so a dependent instruction is accepted in the writeback cycle.
REQ-031 SHALL, without RV32I_SCOREBOARD_WB_BYPASS_EN, use registered busy only; dependent instruction is accepted one cycle after writeback.

Verification
REQ-032 SHALL cover: addi x1,x0,5 (0x00500093) accepted, issue_ready=1 -> issue_valid next cycle, busy[1]=1, inflight=1.
REQ-033 SHALL cover: then add x3,x1,x2 (0x002081B3) offered -> dec_ready=0 until wb_valid,wb_rd=1; accepted that cycle with bypass, next cycle without.
REQ-034 SHALL cover: MAX_INFLIGHT=4, five independent addi to x1..x5, no writeback -> fifth stalls with inflight=4; one wb -> fifth accepted.
REQ-035 SHALL cover: issue_ready=0 with staged instruction -> dec_ready=0, issue_inst unchanged for 3 cycles; issue_ready=1 and new accept same cycle -> back-to-back issue.
REQ-036 SHALL cover: accept addi x7 and wb_valid,wb_rd=7 same cycle -> busy[7]=1, inflight unchanged.
REQ-037 SHALL cover: flush with busy=0x0000000E, inflight=3, issue_valid=1 -> next cycle all zero, issue_valid=0.
